// File: rtl/fft16_frame_serializer.sv
// fft16_frame_serializer: captures whole 16-bin FFT result frames into a
// ping-pong pair of buffers and streams them out one bin per beat over a
// valid/ready interface, optionally in bit-reversed lane order.
module fft16_frame_serializer #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned BITREV = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*DATA_W-1:0]  in_real,
    input  logic [16*DATA_W-1:0]  in_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_real,
    output logic [DATA_W-1:0]     out_imag,
    output logic [3:0]            out_index,
    output logic                  out_last
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    buf_state_t               buf_state [2];
    logic [16*DATA_W-1:0]     frame_real [2];
    logic [16*DATA_W-1:0]     frame_imag [2];
    logic                     wr_sel;
    logic                     rd_sel;
    logic [3:0]               cnt;

    logic [1:0]               full;
    logic [3:0]               lane;
    logic                     capture;
    logic                     beat;

    // Decode per-buffer occupancy and the handshake events of this cycle.
    always_comb begin
        full[0] = (buf_state[0] == BUF_FULL);
        full[1] = (buf_state[1] == BUF_FULL);
        capture = in_valid && in_ready;
        beat    = out_valid && out_ready;
    end

    // Map the beat position to the stored lane (identity or 4-bit reversal).
    generate
        if (BITREV != 0) begin : g_bitrev
            always_comb lane = {cnt[0], cnt[1], cnt[2], cnt[3]};
        end else begin : g_natural
            always_comb lane = cnt;
        end
    endgenerate

    // Handshake and data outputs are a pure mux of registered state.
    always_comb begin
        in_ready  = !rst && !full[wr_sel];
        out_valid = full[rd_sel];
        out_real  = frame_real[rd_sel][lane*DATA_W +: DATA_W];
        out_imag  = frame_imag[rd_sel][lane*DATA_W +: DATA_W];
        out_index = cnt;
        out_last  = full[rd_sel] && (cnt == 4'd15);
    end

    // Buffer FSMs, frame capture and drain sequencing.
    // A capture always targets an empty buffer and a release always a full
    // one, so both may update buf_state in the same cycle without conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_state[0] <= BUF_EMPTY;
            buf_state[1] <= BUF_EMPTY;
            frame_real[0] <= '0;
            frame_real[1] <= '0;
            frame_imag[0] <= '0;
            frame_imag[1] <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            cnt    <= '0;
        end else begin
            if (capture) begin
                frame_real[wr_sel] <= in_real;
                frame_imag[wr_sel] <= in_imag;
                buf_state[wr_sel]  <= BUF_FULL;
                wr_sel             <= ~wr_sel;
            end
            if (beat) begin
                cnt <= cnt + 4'd1;
                if (cnt == 4'd15) begin
                    buf_state[rd_sel] <= BUF_EMPTY;
                    rd_sel            <= ~rd_sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft16_frame_serializer.sv
// Scoreboard testbench for fft16_frame_serializer: one natural-order instance
// and one bit-reversed instance, sharing clock and reset.
module tb_fft16_frame_serializer;

    localparam int unsigned W = 24;

    typedef struct packed {
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic [3:0]   idx;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    logic            a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [16*W-1:0] a_in_real, a_in_imag;
    logic [W-1:0]    a_out_real, a_out_imag;
    logic [3:0]      a_out_index;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [16*W-1:0] b_in_real, b_in_imag;
    logic [W-1:0]    b_out_real, b_out_imag;
    logic [3:0]      b_out_index;

    beat_t q0[$];
    beat_t q1[$];
    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    fft16_frame_serializer #(.DATA_W(W), .BITREV(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_real(a_in_real), .in_imag(a_in_imag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_real(a_out_real), .out_imag(a_out_imag),
        .out_index(a_out_index), .out_last(a_out_last)
    );

    fft16_frame_serializer #(.DATA_W(W), .BITREV(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_real(b_in_real), .in_imag(b_in_imag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_real(b_out_real), .out_imag(b_out_imag),
        .out_index(b_out_index), .out_last(b_out_last)
    );

    // Lane i gets real = bre+i, imag = bim+i.
    task automatic drive_frame_a(input logic [W-1:0] bre, input logic [W-1:0] bim);
        for (int i = 0; i < 16; i++) begin
            a_in_real[i*W +: W] = bre + W'(i);
            a_in_imag[i*W +: W] = bim + W'(i);
        end
    endtask

    // Natural-order expectations for a frame driven by drive_frame_a.
    task automatic push_a(input logic [W-1:0] bre, input logic [W-1:0] bim);
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            e.re   = bre + W'(i);
            e.im   = bim + W'(i);
            e.idx  = 4'(i);
            e.last = (i == 15);
            q0.push_back(e);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_in_real = '0; a_in_imag = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_real = '0; b_in_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b0) $display("FAIL rst_in_ready_held: got %b want 0", a_in_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) $display("FAIL rst_in_ready_after: got %b want 1", a_in_ready);
        else passed++;
        checks++;
        if ({a_out_valid, a_out_last, a_out_index} !== 6'b0)
            $display("FAIL rst_out_ctrl: got valid=%b last=%b idx=%0d want 0/0/0", a_out_valid, a_out_last, a_out_index);
        else passed++;
        checks++;
        if ({a_out_real, a_out_imag} !== '0)
            $display("FAIL rst_out_data: got re=%h im=%h want 0/0", a_out_real, a_out_imag);
        else passed++;
        checks++;
        if ({b_in_ready, b_out_valid} !== 2'b10)
            $display("FAIL rst_dut1: got ready=%b valid=%b want 1/0", b_in_ready, b_out_valid);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_natural;
        beat_t e;
        q0.delete();
        drive_frame_a(W'(1), W'(0));
        for (int i = 0; i < 16; i++) a_in_imag[i*W +: W] = '0;
        for (int i = 0; i < 16; i++) begin
            e.re = W'(i + 1); e.im = '0; e.idx = 4'(i); e.last = (i == 15);
            q0.push_back(e);
        end
        a_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) $display("FAIL nat_in_ready: got %b want 1", a_in_ready);
        else passed++;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1) $display("FAIL nat_gap: cycle %0d got valid=%b want 1", c, a_out_valid);
            else if (q0.size() == 0) $display("FAIL nat_underflow: unexpected beat idx=%0d", a_out_index);
            else begin
                e = q0.pop_front();
                if ({a_out_real, a_out_imag, a_out_index, a_out_last} !== e)
                    $display("FAIL nat_beat: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                             a_out_real, a_out_imag, a_out_index, a_out_last, e.re, e.im, e.idx, e.last);
                else passed++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) $display("FAIL nat_end: got valid=%b want 0", a_out_valid);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_bitrev;
        beat_t e;
        int unsigned br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        q1.delete();
        for (int i = 0; i < 16; i++) begin
            b_in_real[i*W +: W] = W'(i);
            b_in_imag[i*W +: W] = W'(100 + i);
        end
        for (int k = 0; k < 16; k++) begin
            e.re = W'(br_tab[k]); e.im = W'(100 + br_tab[k]); e.idx = 4'(k); e.last = (k == 15);
            q1.push_back(e);
        end
        b_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (b_in_ready !== 1'b1) $display("FAIL br_in_ready: got %b want 1", b_in_ready);
        else passed++;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (b_out_valid !== 1'b1) $display("FAIL br_gap: cycle %0d got valid=%b want 1", c, b_out_valid);
            else if (q1.size() == 0) $display("FAIL br_underflow: unexpected beat idx=%0d", b_out_index);
            else begin
                e = q1.pop_front();
                if ({b_out_real, b_out_imag, b_out_index, b_out_last} !== e)
                    $display("FAIL br_beat: got re=%0d im=%0d idx=%0d last=%b want re=%0d im=%0d idx=%0d last=%b",
                             b_out_real, b_out_imag, b_out_index, b_out_last, e.re, e.im, e.idx, e.last);
                else passed++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0) $display("FAIL br_end: got valid=%b want 0", b_out_valid);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        beat_t e;
        int beats = 0;
        int stalls = 0;
        int seen5 = 0;
        q0.delete();
        drive_frame_a(W'(1), W'(0));
        push_a(W'(1), W'(0));
        a_in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) $display("FAIL bp_in_ready: got %b want 1", a_in_ready);
        else passed++;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int c = 0; c < 40 && beats < 16; c++) begin
            a_out_ready = !(beats == 5 && stalls < 3);
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1) $display("FAIL bp_gap: cycle %0d got valid=%b want 1", c, a_out_valid);
            else if (q0.size() == 0) $display("FAIL bp_underflow: unexpected beat idx=%0d", a_out_index);
            else begin
                e = q0[0];
                if (a_out_index == 4'd5) seen5++;
                if ({a_out_real, a_out_imag, a_out_index, a_out_last} !== e)
                    $display("FAIL bp_beat: got re=%h idx=%0d last=%b want re=%h idx=%0d last=%b",
                             a_out_real, a_out_index, a_out_last, e.re, e.idx, e.last);
                else passed++;
                if (a_out_ready) begin
                    void'(q0.pop_front());
                    beats++;
                end else stalls++;
            end
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        checks++;
        if (beats != 16) $display("FAIL bp_beat_count: got %0d want 16", beats);
        else passed++;
        checks++;
        if (seen5 != 4) $display("FAIL bp_hold_cycles: got %0d want 4", seen5);
        else passed++;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) $display("FAIL bp_end: got valid=%b want 0", a_out_valid);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_ping_pong;
        beat_t e;
        bit c_taken = 1'b0;
        q0.delete();
        for (int c = 0; c < 50; c++) begin
            if (c == 0) begin
                drive_frame_a(W'('h100), W'('h180)); a_in_valid = 1'b1;
            end else if (c == 1) begin
                drive_frame_a(W'('h200), W'('h280)); a_in_valid = 1'b1;
            end else if (!c_taken) begin
                drive_frame_a(W'('h300), W'('h380)); a_in_valid = 1'b1;
            end else a_in_valid = 1'b0;
            @(negedge clk);
            if (c < 2) begin
                checks++;
                if (a_in_ready !== 1'b1) $display("FAIL pp_accept_ab: cycle %0d got ready=%b want 1", c, a_in_ready);
                else passed++;
                if (c == 0) push_a(W'('h100), W'('h180));
                else push_a(W'('h200), W'('h280));
            end else if (!c_taken) begin
                checks++;
                if (c <= 16) begin
                    if (a_in_ready !== 1'b0) $display("FAIL pp_full: cycle %0d got ready=%b want 0", c, a_in_ready);
                    else passed++;
                end else begin
                    if (c != 17 || a_in_ready !== 1'b1)
                        $display("FAIL pp_c_accept: cycle %0d got ready=%b want 1 at cycle 17", c, a_in_ready);
                    else passed++;
                end
                if (a_in_ready) begin
                    push_a(W'('h300), W'('h380));
                    c_taken = 1'b1;
                end
            end
            if (c >= 1 && c <= 48) begin
                checks++;
                if (a_out_valid !== 1'b1) $display("FAIL pp_gap: cycle %0d got valid=%b want 1", c, a_out_valid);
                else if (q0.size() == 0) $display("FAIL pp_underflow: unexpected beat re=%h", a_out_real);
                else begin
                    e = q0.pop_front();
                    if ({a_out_real, a_out_imag, a_out_index, a_out_last} !== e)
                        $display("FAIL pp_beat: cycle %0d got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                                 c, a_out_real, a_out_imag, a_out_index, a_out_last, e.re, e.im, e.idx, e.last);
                    else passed++;
                end
            end else begin
                checks++;
                if (a_out_valid !== 1'b0) $display("FAIL pp_idle: cycle %0d got valid=%b want 0", c, a_out_valid);
                else passed++;
            end
            @(posedge clk); #1;
        end
        a_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        beat_t e;
        q0.delete();
        drive_frame_a(W'(1), W'(0));
        push_a(W'(1), W'(0));
        a_in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            e = q0.pop_front();
            if ({a_out_valid, a_out_real, a_out_index} !== {1'b1, e.re, e.idx})
                $display("FAIL rm_pre: got valid=%b re=%h idx=%0d want 1 re=%h idx=%0d",
                         a_out_valid, a_out_real, a_out_index, e.re, e.idx);
            else passed++;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_index, a_in_ready} !== {1'b1, 4'd7, 1'b0})
            $display("FAIL rm_at7: got valid=%b idx=%0d ready=%b want 1/7/0", a_out_valid, a_out_index, a_in_ready);
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_real, a_out_index, a_in_ready} !== {1'b0, W'(0), 4'd0, 1'b1})
            $display("FAIL rm_after: got valid=%b re=%h idx=%0d ready=%b want 0/0/0/1",
                     a_out_valid, a_out_real, a_out_index, a_in_ready);
        else passed++;
        drive_frame_a(W'('h40), W'('h60));
        push_a(W'('h40), W'('h60));
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1) $display("FAIL rm_gap: cycle %0d got valid=%b want 1", c, a_out_valid);
            else if (q0.size() == 0) $display("FAIL rm_underflow: unexpected beat idx=%0d", a_out_index);
            else begin
                e = q0.pop_front();
                if ({a_out_real, a_out_imag, a_out_index, a_out_last} !== e)
                    $display("FAIL rm_beat: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                             a_out_real, a_out_imag, a_out_index, a_out_last, e.re, e.im, e.idx, e.last);
                else passed++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0) $display("FAIL rm_end: got valid=%b want 0", a_out_valid);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_sign;
        beat_t e;
        q0.delete();
        drive_frame_a(W'('h7FFFF0), W'('hFFFFF0));
        a_in_real[0 +: W] = 24'hFFFFFF;
        a_in_imag[0 +: W] = 24'h800000;
        for (int i = 0; i < 16; i++) begin
            e.re = (i == 0) ? 24'hFFFFFF : W'('h7FFFF0) + W'(i);
            e.im = (i == 0) ? 24'h800000 : W'('hFFFFF0) + W'(i);
            e.idx = 4'(i); e.last = (i == 15);
            q0.push_back(e);
        end
        a_in_valid = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b1) $display("FAIL sign_gap: cycle %0d got valid=%b want 1", c, a_out_valid);
            else if (q0.size() == 0) $display("FAIL sign_underflow: unexpected beat idx=%0d", a_out_index);
            else begin
                e = q0.pop_front();
                if ({a_out_real, a_out_imag, a_out_index, a_out_last} !== e)
                    $display("FAIL sign_beat: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                             a_out_real, a_out_imag, a_out_index, a_out_last, e.re, e.im, e.idx, e.last);
                else passed++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_bitrev();
        test_backpressure();
        test_ping_pong();
        test_reset_mid();
        test_sign();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule
